// File: rtl/imu_pkg.sv
// Shared definitions for the IMU bias-correction pipeline.
// Word width, channel map, saturation limits and FSM encoding.
package imu_pkg;

    localparam int W     = 16;
    localparam int SW    = W + 2;
    localparam int NCH   = 7;
    localparam int ACC_Z = 2;

    // Limits at working width so the offset add cannot wrap.
    localparam logic signed [SW-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [SW-1:0] SAT_MIN = -18'sd32768;

    typedef logic signed [W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_sub16.sv
// Raw minus bias, plus a constant offset, saturated to a signed 16-bit word.
// Purely combinational; the caller registers the result.
module sat_sub16
    import imu_pkg::*;
#(
    parameter logic signed [W-1:0] OFFSET = '0
) (
    input  logic signed [W-1:0] i_raw,
    input  logic signed [W-1:0] i_bias,
    output logic signed [W-1:0] o_res
);

    logic signed [W:0]    w_diff;
    logic signed [SW-1:0] w_sum;

    assign w_diff = {i_raw[W-1], i_raw} - {i_bias[W-1], i_bias};
    assign w_sum  = {w_diff[W], w_diff} + {{2{OFFSET[W-1]}}, OFFSET};

    always_comb begin
        o_res = w_sum[W-1:0];
        if (w_sum > SAT_MAX) begin
            o_res = SAT_MAX[W-1:0];
        end else if (w_sum < SAT_MIN) begin
            o_res = SAT_MIN[W-1:0];
        end
    end

endmodule

// File: rtl/imu_bias_correct.sv
// Latches calibration biases, then streams bias-corrected IMU samples
// through a two-stage pipeline with a sample counter.
module imu_bias_correct
    import imu_pkg::*;
#(
    parameter logic signed [15:0] ACC_Z_OFFSET = 16'sd0,
    parameter int                 CNT_W        = 16
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic signed [15:0]  acc_x_in,
    input  logic signed [15:0]  acc_y_in,
    input  logic signed [15:0]  acc_z_in,
    input  logic signed [15:0]  temp_in,
    input  logic signed [15:0]  gyro_x_in,
    input  logic signed [15:0]  gyro_y_in,
    input  logic signed [15:0]  gyro_z_in,
    input  logic                i2c_ack_5_pos_in,
    input  logic                calib_done_in,
    input  logic                key_flag_in,
    input  logic signed [15:0]  acc_x_bias_in,
    input  logic signed [15:0]  acc_y_bias_in,
    input  logic signed [15:0]  acc_z_bias_in,
    input  logic signed [15:0]  temp_bias_in,
    input  logic signed [15:0]  gyro_x_bias_in,
    input  logic signed [15:0]  gyro_y_bias_in,
    input  logic signed [15:0]  gyro_z_bias_in,
    output logic signed [15:0]  acc_x_out,
    output logic signed [15:0]  acc_y_out,
    output logic signed [15:0]  acc_z_out,
    output logic signed [15:0]  temp_out,
    output logic signed [15:0]  gyro_x_out,
    output logic signed [15:0]  gyro_y_out,
    output logic signed [15:0]  gyro_z_out,
    output logic                data_valid_out,
    output logic [CNT_W-1:0]    sample_cnt_out,
    output logic                running_out
);

    state_t            r_state;
    logic              r_running;
    logic              r_s1_vld;
    logic              r_valid;
    logic [CNT_W-1:0]  r_cnt;
    word_t             r_bias [NCH];
    word_t             r_s1   [NCH];
    word_t             r_out  [NCH];
    word_t             w_raw  [NCH];
    word_t             w_bin  [NCH];
    word_t             w_corr [NCH];
    logic              w_leave;
    logic              w_accept;
    logic              w_fire;
    logic              w_start;

    assign w_raw = '{acc_x_in, acc_y_in, acc_z_in, temp_in,
                     gyro_x_in, gyro_y_in, gyro_z_in};
    assign w_bin = '{acc_x_bias_in, acc_y_bias_in, acc_z_bias_in,
                     temp_bias_in, gyro_x_bias_in, gyro_y_bias_in,
                     gyro_z_bias_in};

    assign w_leave  = (r_state == ST_RUN) && (key_flag_in || !calib_done_in);
    assign w_accept = (r_state == ST_RUN) && !key_flag_in && i2c_ack_5_pos_in;
    assign w_start  = (r_state == ST_IDLE) && calib_done_in;
    // A stage-1 sample only completes if the FSM stays in RUN.
    assign w_fire   = r_s1_vld && (r_state == ST_RUN) && !w_leave;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            for (int i = 0; i < NCH; i++) r_bias[i] <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (calib_done_in) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_bias    <= w_bin;
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                end
                ST_RUN: begin
                    if (w_leave) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_s1[i]  <= '0;
                r_out[i] <= '0;
            end
        end else begin
            r_s1_vld <= w_accept;
            r_valid  <= w_fire;
            if (w_accept) r_s1 <= w_raw;
            if (w_fire) r_out <= w_corr;
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_fire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        sat_sub16 #(
            .OFFSET (g == ACC_Z ? ACC_Z_OFFSET : 16'sd0)
        ) u_sat (
            .i_raw  (r_s1[g]),
            .i_bias (r_bias[g]),
            .o_res  (w_corr[g])
        );
    end

    assign acc_x_out      = r_out[0];
    assign acc_y_out      = r_out[1];
    assign acc_z_out      = r_out[2];
    assign temp_out       = r_out[3];
    assign gyro_x_out     = r_out[4];
    assign gyro_y_out     = r_out[5];
    assign gyro_z_out     = r_out[6];
    assign data_valid_out = r_valid;
    assign sample_cnt_out = r_cnt;
    assign running_out    = r_running;

endmodule
